mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Memory-stage controller directly downstream of the execute ALU. Takes the ALU
//  result (address or pass-through value) and store data, runs the multi-cycle
//  data-memory handshake, stalls upstream until the access completes, and
//  presents one registered writeback beat per retired op. Watchdog flags hung accesses.
// PARAMETERS
//  TIMEOUT  64  WAIT cycles without mem_done before err is raised (2..255)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   async active-high reset
//  ex_valid     in   1   op from execute valid this cycle
//  ex_alu_res   in   16  ALU result: memory address, or pass-through value
//  ex_wdata     in   16  store data
//  ex_mem_rd    in   1   op is a load
//  ex_mem_wr    in   1   op is a store
//  stall_o      out  1   upstream must hold ex_* and not advance
//  mem_addr     out  16  data-memory address
//  mem_wdata    out  16  data-memory write data
//  mem_rd       out  1   read request
//  mem_wr       out  1   write request
//  mem_stall    in   1   memory busy, request not accepted
//  mem_done     in   1   access complete, mem_rdata valid
//  mem_rdata    in   16  read data
//  wb_valid     out  1   one-cycle pulse, op retired
//  wb_data      out  16  mem_rdata for loads, latched ex_alu_res otherwise
//  err          out  1   sticky error
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; latches and counter 0. rst aborts
//    any access immediately, with mem_rd/mem_wr low the same cycle.
//  - States: IDLE, REQ, WAIT, ERR.
//  - IDLE, ex_valid & !rd & !wr: next cycle wb_valid=1, wb_data=ex_alu_res.
//    Stay IDLE; stall_o=0 (latency 1, full throughput).
//  - IDLE, ex_valid & (rd^wr): latch addr/wdata/type. Go to REQ.
//    stall_o=1 combinationally this cycle.
//  - IDLE, ex_valid & rd & wr: go to ERR.
//  - REQ: drive mem_rd or mem_wr with the latched addr/wdata.
//    mem_stall=1: stay in REQ and re-present the request.
//    Else mem_done=1: retire. Else go to WAIT, counter cleared.
//    stall_o=1 unless retiring.
//  - WAIT: requests low. Counter +1 per cycle.
//    mem_done=1: retire, stall_o=0 that cycle, go to IDLE.
//    Counter==TIMEOUT-1 without done: go to ERR.
//  - Retire: the cycle after mem_done, wb_valid=1. wb_data=mem_rdata
//    (sampled on the done cycle) for a load, latched address for a store.
//  - ex_* are ignored in REQ and WAIT. Upstream advances on any cycle with
//    stall_o=0.
//  - ERR: err=1, stall_o=1, requests 0, wb_valid 0. Left only by rst.
//  - mem_done in IDLE or ERR is ignored.
//  - mem_done and timeout in the same cycle: done wins.
//  - The counter saturates and never wraps.
// CONFIGURATION
//  ALIGN_CHECK_EN defined:
//    mem op with ex_alu_res[0]=1 goes IDLE->ERR, no request issued.
//  Undefined:
//    address passed unchanged, no alignment check.
// TESTING
//  1 Non-mem op, alu_res=16'h1234 -> next cycle wb_valid=1, wb_data=16'h1234,
//    stall_o never 1.
//  2 Load addr 16'h0040, mem_done 3 cycles after REQ, rdata=16'hBEEF ->
//    mem_rd high 1 cycle, stall_o high until done, then wb_data=16'hBEEF.
//  3 Store with mem_stall=1 for 2 cycles -> mem_wr held 3 cycles, addr/wdata stable.
//    Done -> wb_valid pulse.
//  4 Load, no mem_done, TIMEOUT=8 -> err=1 after 8 WAIT cycles, stall_o stuck 1.
//    rst clears all.
//  5 ex_mem_rd=ex_mem_wr=1 -> ERR. With ALIGN_CHECK_EN, load addr 16'h0041 -> ERR,
//    no mem_rd pulse.
//  6 rst asserted mid-WAIT -> outputs 0 without a clock edge.
//    Next op after release completes normally.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller (ALU result -> data-memory handshake -> writeback beat).
// Define ALIGN_CHECK_EN to send odd-address memory ops straight to the error state.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [15:0] ex_alu_res,
  input  logic [15:0] ex_wdata,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  output logic        stall_o,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_stall,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic        err
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERR} state_t;
  state_t      state_q;
  logic [15:0] addr_q, wdata_q, wb_data_q;
  logic [7:0]  cnt_q;
  logic        ld_q, wb_valid_q;
  logic        mem_op, bad_op, retire;
  assign mem_op = ex_valid && (ex_mem_rd || ex_mem_wr);
`ifdef ALIGN_CHECK_EN
  assign bad_op = (ex_mem_rd && ex_mem_wr) || ex_alu_res[0];
`else
  assign bad_op = ex_mem_rd && ex_mem_wr;
`endif
  assign retire = mem_done && (state_q == S_WAIT || (state_q == S_REQ && !mem_stall));
  // Gated by rst so every output reads 0 while reset is held, even with a mem op waiting upstream.
  assign stall_o = !rst && (state_q == S_IDLE ? mem_op : (state_q == S_ERR || !retire));
  assign mem_rd    = state_q == S_REQ && ld_q;
  assign mem_wr    = state_q == S_REQ && !ld_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign err       = state_q == S_ERR;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_data_q  <= '0;
      cnt_q      <= '0;
      ld_q       <= 1'b0;
      wb_valid_q <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_op && bad_op) state_q <= S_ERR;
          else if (mem_op) begin
            state_q <= S_REQ;
            addr_q  <= ex_alu_res;
            wdata_q <= ex_wdata;
            ld_q    <= ex_mem_rd;
          end else if (ex_valid) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= ex_alu_res;
          end
        end
        S_REQ: begin
          if (!mem_stall && !mem_done) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end
        end
        S_WAIT: begin
          if (!mem_done && cnt_q == 8'(TIMEOUT - 1)) state_q <= S_ERR;
          else if (!mem_done && cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
        end
        default: ;
      endcase
      if (retire) begin
        state_q    <= S_IDLE;
        wb_valid_q <= 1'b1;
        wb_data_q  <= ld_q ? mem_rdata : addr_q;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: random op stream against a transaction-level model, plus directed timeout/error/reset cases.
module tb_mem_stage_ctrl;
  logic        clk, rst, ex_valid, ex_mem_rd, ex_mem_wr, mem_stall, mem_done;
  logic [15:0] ex_alu_res, ex_wdata, mem_rdata;
  logic        stall_o, mem_rd, mem_wr, wb_valid, err;
  logic [15:0] mem_addr, mem_wdata, wb_data;
  int n_err = 0;
  int n_chk = 0;

  mem_stage_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_res(ex_alu_res), .ex_wdata(ex_wdata),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .stall_o(stall_o), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_stall(mem_stall),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data), .err(err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] d, input logic st, input logic dn, input logic [15:0] rdat);
    @(negedge clk);
    ex_valid = v; ex_mem_rd = rd; ex_mem_wr = wr; ex_alu_res = a; ex_wdata = d;
    mem_stall = st; mem_done = dn; mem_rdata = rdat;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    ex_valid = 0; ex_mem_rd = 0; ex_mem_wr = 0; mem_stall = 0; mem_done = 0;
    #1 rst = 1;
    #1;
    check("rst_stall", stall_o, 0);
    check("rst_req", {mem_rd, mem_wr}, 0);
    check("rst_err", err, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_addr", mem_addr, 0);
    @(negedge clk);
    rst = 0;
  endtask

  logic [15:0] op_a, op_d, pd;
  logic        op_v, op_rd, op_wr, pv, done;
  bit          have_op, busy, reqph;
  int          stall_left, wait_left, k;

  initial begin
    rst = 0; ex_valid = 0; ex_mem_rd = 0; ex_mem_wr = 0; ex_alu_res = 0; ex_wdata = 0;
    mem_stall = 0; mem_done = 0; mem_rdata = 0;
    #3 rst = 1;
    #1;
    check("init_stall", stall_o, 0);
    check("init_err", err, 0);
    check("init_wbv", wb_valid, 0);
    @(negedge clk);
    rst = 0;

    // Random phase: upstream holds each op until stall_o=0; responder picks stall and latency per op.
    have_op = 0; busy = 0; reqph = 0; pv = 0; pd = 0; stall_left = 0; wait_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      check("wb_valid", wb_valid, pv);
      if (pv) check("wb_data", wb_data, pd);
      pv = 0;
      if (!have_op) begin
        op_v = $urandom_range(0, 3) != 0;
        k = $urandom_range(0, 2);
        op_rd = k == 1;
        op_wr = k == 2;
        op_a = 16'($urandom);
        if (op_rd || op_wr) op_a[0] = 1'b0;
        op_d = 16'($urandom);
        have_op = 1;
      end
      ex_valid = op_v; ex_mem_rd = op_rd; ex_mem_wr = op_wr; ex_alu_res = op_a; ex_wdata = op_d;
      mem_stall = 0;
      mem_done = busy ? 1'b0 : 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      #1;
      check("req", mem_rd || mem_wr, reqph);
      done = 0;
      if (reqph) begin
        check("req_rd", mem_rd, op_rd);
        check("req_addr", mem_addr, op_a);
        if (op_wr) check("req_wdata", mem_wdata, op_d);
        if (stall_left > 0) begin
          mem_stall = 1;
          mem_done = 1'($urandom_range(0, 1));
          stall_left--;
        end else begin
          reqph = 0;
          done = wait_left == 0;
        end
      end else if (busy && wait_left > 0) begin
        wait_left--;
        done = wait_left == 0;
      end
      if (busy && !(reqph && mem_stall)) mem_done = done;
      #1;
      if (busy) begin
        check("stall_busy", stall_o, !done);
        if (done) begin
          pv = 1;
          pd = op_rd ? mem_rdata : op_a;
          busy = 0;
          have_op = 0;
        end
      end else begin
        check("stall_idle", stall_o, op_v && (op_rd || op_wr));
        if (op_v && (op_rd || op_wr)) begin
          busy = 1; reqph = 1;
          stall_left = $urandom_range(0, 2);
          wait_left = $urandom_range(0, 3);
        end else begin
          if (op_v) begin pv = 1; pd = op_a; end
          have_op = 0;
        end
      end
    end

    // Non-mem op: one-cycle writeback, no stall.
    do_reset();
    cyc(1, 0, 0, 16'h1234, 0, 0, 0, 0);
    check("t1_stall", stall_o, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_wbv", wb_valid, 1);
    check("t1_wbd", wb_data, 16'h1234);

    // Load with done on the third cycle after REQ.
    cyc(1, 1, 0, 16'h0040, 0, 0, 0, 0);
    check("t2_stall0", stall_o, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_rd", mem_rd, 1);
    check("t2_addr", mem_addr, 16'h0040);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_rd_low", mem_rd, 0);
    check("t2_stall1", stall_o, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 16'hBEEF);
    check("t2_stall_done", stall_o, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_wbv", wb_valid, 1);
    check("t2_wbd", wb_data, 16'hBEEF);

    // Timeout: 8 WAIT cycles without done -> ERR; late done ignored.
    cyc(1, 1, 0, 16'h0080, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_rd", mem_rd, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      check("t4_wait_err", err, 0);
      check("t4_wait_stall", stall_o, 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_err", err, 1);
    check("t4_stall", stall_o, 1);
    cyc(1, 0, 0, 16'h7777, 0, 0, 1, 16'h1111);
    check("t4_err_hold", err, 1);
    check("t4_req_low", {mem_rd, mem_wr}, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_no_wb", wb_valid, 0);
    do_reset();

    // Load and store together is illegal.
    cyc(1, 1, 1, 16'h0010, 0, 0, 0, 0);
    check("t5_stall", stall_o, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_err", err, 1);
    check("t5_req", {mem_rd, mem_wr}, 0);
`ifdef ALIGN_CHECK_EN
    do_reset();
    cyc(1, 1, 0, 16'h0041, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_align_err", err, 1);
    check("t5_align_rd", mem_rd, 0);
`endif

    // Async reset mid-WAIT, then a store completes normally.
    do_reset();
    cyc(1, 1, 0, 16'h0100, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_wait_addr", mem_addr, 16'h0100);
    #1 rst = 1;
    #1;
    check("t6_async_addr", mem_addr, 0);
    check("t6_async_stall", stall_o, 0);
    check("t6_async_req", {mem_rd, mem_wr}, 0);
    @(negedge clk);
    rst = 0;
    cyc(1, 0, 1, 16'h0200, 16'h5555, 0, 0, 0);
    check("t6_stall", stall_o, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    check("t6_wr", mem_wr, 1);
    check("t6_wdata", mem_wdata, 16'h5555);
    check("t6_stall_done", stall_o, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_wbv", wb_valid, 1);
    check("t6_wbd", wb_data, 16'h0200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
